bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Shares the single TileLink-UL memory port between instruction fetch (port 0, instcache refill)
//  and the data side (port 1, LSU/dcache). Sits between the two requesters and the bus master
//  interface. Grants one transaction at a time, round-robin, and holds the grant until the
//  last D-channel beat. Routes response beats back to the owner.
//  Supports dropping the fetch response on branch/trap redirect.
// PARAMETERS
//  AW        64   address width
//  DW        64   data/beat width; beat = 8 bytes
//  MAX_BEATS 8    max beats per transaction; beat counter is $clog2(MAX_BEATS)+1 bits
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   synchronous reset, active-low
//  req0/req1  in   1   requester i wants a transaction; held with payload until gnt_i
//  op0/op1    in   3   TileLink A opcode (Get=4, PutFullData=0)
//  size0/size1 in  3   log2 bytes of transfer
//  addr0/addr1 in  AW  byte address
//  wdata0/wdata1 in DW write data (single-beat puts only)
//  gnt0/gnt1  out  1   one-cycle pulse: requester i's A beat accepted by bus
//  flush0     in   1   fetch redirect: drop port-0 responses still in flight
//  rvalid0/rvalid1 out 1 response beat valid for requester i
//  rdata      out  DW  response data (shared, qualified by rvalid_i)
//  rlast      out  1   last beat of transaction, qualified by rvalid_i
//  busy       out  1   transaction in progress (state != IDLE)
//  a_valid    out  1   A channel valid
//  a_ready    in   1   A channel ready
//  a_opcode   out  3   A opcode
//  a_size     out  3   A size
//  a_address  out  AW  A address
//  a_data     out  DW  A data
//  d_valid    in   1   D channel valid
//  d_ready    out  1   D channel ready
//  d_data     in   DW  D data
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, owner=0, last=1 (port 0 wins first tie), beat_cnt=0,
//   drop=0. Outputs: a_valid=0, gnt*=0, rvalid*=0, rlast=0, busy=0; a_* payload=0, d_ready=0.
//   Reset mid-transaction abandons it; no response forwarded afterwards.
//  FSM IDLE -> A -> D -> IDLE.
//  IDLE: if any req, pick owner (req0&req1: port != last; else the single requester),
//   latch op/size/addr/wdata into A regs, beats = (size<=3) ? 1 : min(1<<(size-3), MAX_BEATS);
//   -> A next cycle. Arbitration costs exactly 1 cycle.
//  A: a_valid=1, payload from regs (stable while !a_ready). On a_valid&a_ready: gnt_owner=1 that
//   cycle, last<=owner, beat_cnt<=beats, -> D.
//  D: d_ready=1. Each d_valid: beat_cnt--, rdata=d_data combinationally, rvalid_owner=d_valid&!drop,
//   rlast=(beat_cnt==1). On last beat -> IDLE. PutFullData gets one AccessAck beat (beats=1).
//  Back-to-back: IDLE is re-entered for one cycle after every transaction (no bypass).
//  flush0: in A or D with owner=0, sets drop=1. Transaction still completes on the bus, D beats
//   consumed with rvalid0=0. drop clears on return to IDLE.
//   flush0 in IDLE or with owner=1: no effect.
//   flush0 on the cycle of the A handshake: gnt0 still pulses; drop set.
//  Requester withdrawing req before gnt: not allowed. Latched payload used regardless.
//  d_valid in IDLE/A: ignored (d_ready=0). beat_cnt never underflows.
// TESTING
//  1 reset, req0 only, Get size=5 addr=0x8000_0000, a_ready=1 -> a_valid cycle 2, gnt0 one cycle,
//    4 D beats -> rvalid0 x4, rlast on 4th, busy low after.
//  2 req0&req1 same cycle from reset -> port0 served first, then port1; repeat -> alternates 0,1,0,1.
//  3 a_ready low 5 cycles in A -> a_valid/a_address stable, gnt1 only on ready cycle.
//  4 flush0 after 2nd of 4 fetch beats -> beats 3,4 consumed (d_ready=1), rvalid0=0, then port1
//    granted next.
//  5 Put size=3 wdata=0xDEADBEEF from port1 -> a_data=0xDEADBEEF, one D beat -> rvalid1&rlast.
//  6 rst_n low during D beat 2 -> all outputs zero next cycle, later d_valid not forwarded.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// TileLink-UL A/D channel bundle between the arbiter (master) and the memory port (slave).
interface bus_arbiter_if #(
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 64
);
  logic          a_valid;
  logic          a_ready;
  logic [2:0]    a_opcode;
  logic [2:0]    a_size;
  logic [AW-1:0] a_address;
  logic [DW-1:0] a_data;
  logic          d_valid;
  logic          d_ready;
  logic [DW-1:0] d_data;

  modport master (
    output a_valid, a_opcode, a_size, a_address, a_data, d_ready,
    input  a_ready, d_valid, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_address, a_data, d_ready,
    output a_ready, d_valid, d_data
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one TileLink-UL port between fetch (port 0) and data (port 1);
// grant is held until the last D beat, and fetch responses can be dropped on redirect.
module bus_arbiter #(
  parameter int unsigned AW        = 64,
  parameter int unsigned DW        = 64,
  parameter int unsigned MAX_BEATS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [2:0]    op0,
  input  logic [2:0]    op1,
  input  logic [2:0]    size0,
  input  logic [2:0]    size1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  input  logic          flush0,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          rlast,
  output logic          busy,
  bus_arbiter_if.master bus
);
  localparam int unsigned CW = $clog2(MAX_BEATS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_A, S_D} state_t;

  state_t        state, state_nx;
  logic          owner, owner_nx;
  logic          last, last_nx;
  logic          drop, drop_nx;
  logic [CW-1:0] beats, beats_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    op_q, op_nx;
  logic [2:0]    size_q, size_nx;
  logic [AW-1:0] addr_q, addr_nx;
  logic [DW-1:0] data_q, data_nx;

  logic          sel;
  logic [2:0]    sel_size;
  logic [CW-1:0] sel_beats;

  // Winner selection and beat count of the winner's request (1 beat up to 8 bytes, capped).
  always_comb begin
    sel      = (req0 & req1) ? ~last : req1;
    sel_size = sel ? size1 : size0;
    if (sel_size <= 3'd3)
      sel_beats = CW'(1);
    else if ((32'(1) << (sel_size - 3'd3)) >= 32'(MAX_BEATS))
      sel_beats = CW'(MAX_BEATS);
    else
      sel_beats = CW'(32'(1) << (sel_size - 3'd3));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      owner  <= 1'b0;
      last   <= 1'b1;
      drop   <= 1'b0;
      beats  <= '0;
      cnt    <= '0;
      op_q   <= '0;
      size_q <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      last   <= last_nx;
      drop   <= drop_nx;
      beats  <= beats_nx;
      cnt    <= cnt_nx;
      op_q   <= op_nx;
      size_q <= size_nx;
      addr_q <= addr_nx;
      data_q <= data_nx;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    drop_nx  = drop;
    beats_nx = beats;
    cnt_nx   = cnt;
    op_nx    = op_q;
    size_nx  = size_q;
    addr_nx  = addr_q;
    data_nx  = data_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    rvalid0  = 1'b0;
    rvalid1  = 1'b0;
    rlast    = 1'b0;
    rdata    = '0;
    case (state)
      S_IDLE: begin
        drop_nx = 1'b0;
        if (req0 | req1) begin
          state_nx = S_A;
          owner_nx = sel;
          beats_nx = sel_beats;
          op_nx    = sel ? op1 : op0;
          size_nx  = sel_size;
          addr_nx  = sel ? addr1 : addr0;
          data_nx  = sel ? wdata1 : wdata0;
        end
      end
      S_A: begin
        if (flush0 && !owner) drop_nx = 1'b1;
        if (bus.a_ready) begin
          gnt0     = ~owner;
          gnt1     = owner;
          last_nx  = owner;
          cnt_nx   = beats;
          state_nx = S_D;
        end
      end
      S_D: begin
        if (flush0 && !owner) drop_nx = 1'b1;
        if (bus.d_valid) begin
          rdata   = bus.d_data;
          rvalid0 = ~owner & ~drop;
          rvalid1 = owner & ~drop;
          rlast   = (cnt == CW'(1));
          if (cnt != '0) cnt_nx = cnt - CW'(1);
          // Final beat: drop is a per-transaction flag, so it clears here too.
          if (cnt <= CW'(1)) begin
            state_nx = S_IDLE;
            drop_nx  = 1'b0;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy          = (state != S_IDLE);
  assign bus.a_valid   = (state == S_A);
  assign bus.d_ready   = (state == S_D);
  assign bus.a_opcode  = op_q;
  assign bus.a_size    = size_q;
  assign bus.a_address = addr_q;
  assign bus.a_data    = data_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: table of transactions plus hand-written corner sequences.
module tb_bus_arbiter;
  localparam logic [2:0] GET = 3'd4;
  localparam logic [2:0] PUT = 3'd0;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, flush0;
  logic [2:0]  op0, op1, size0, size1;
  logic [63:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, rlast, busy;
  logic [63:0] rdata;

  bus_arbiter_if #(.AW(64), .DW(64)) bus ();

  bus_arbiter #(.AW(64), .DW(64), .MAX_BEATS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .op0(op0), .op1(op1), .size0(size0), .size1(size1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .flush0(flush0),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata), .rlast(rlast), .busy(busy),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          v0;
    bit          v1;
    logic [63:0] data;
    bit          last;
  } beat_t;

  typedef struct {
    int          post;      // 0: port0, 1: port1, 2: both, 3: nothing new
    logic [2:0]  op;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          stall;     // cycles of a_ready low in A
    int          flush_at;  // -1 none, 0 on A handshake, k before beat k
    bit          owner;
    int          beats;
  } vec_t;

  beat_t sb[$];
  vec_t  tbl[12];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, " a_valid"}, 64'(bus.a_valid), 64'd0);
    chk({tag, " gnt"}, 64'({gnt0, gnt1}), 64'd0);
    chk({tag, " rvalid"}, 64'({rvalid0, rvalid1}), 64'd0);
    chk({tag, " rlast"}, 64'(rlast), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " d_ready"}, 64'(bus.d_ready), 64'd0);
    chk({tag, " a_opcode"}, 64'(bus.a_opcode), 64'd0);
    chk({tag, " a_size"}, 64'(bus.a_size), 64'd0);
    chk({tag, " a_address"}, bus.a_address, 64'd0);
    chk({tag, " a_data"}, bus.a_data, 64'd0);
  endtask

  task automatic post(input int which, input logic [2:0] op, input logic [2:0] size,
                      input logic [63:0] addr, input logic [63:0] wdata);
    if (which == 0 || which == 2) begin
      req0 = 1'b1; op0 = op; size0 = size; addr0 = addr; wdata0 = wdata;
    end
    if (which == 1 || which == 2) begin
      req1 = 1'b1; op1 = op; size1 = size; wdata1 = wdata;
      addr1 = (which == 2) ? addr + 64'h40 : addr;
    end
  endtask

  // Entered one time unit after a posedge with the DUT in IDLE; returns the same way.
  task automatic serve(input bit o, input int beats, input int stall, input int flush_at);
    logic [63:0] ea, ew, dd;
    logic [2:0]  eo, es;
    beat_t       e;
    bit          dropped;
    ea = o ? addr1 : addr0;
    ew = o ? wdata1 : wdata0;
    eo = o ? op1 : op0;
    es = o ? size1 : size0;
    @(negedge clk);
    chk("arb busy", 64'(busy), 64'd0);
    chk("arb a_valid", 64'(bus.a_valid), 64'd0);
    for (int c = 0; c <= stall; c++) begin
      @(posedge clk); #1;
      bus.a_ready = (c == stall);
      flush0      = (c == stall) && (flush_at == 0);
      bus.d_valid = (c < stall);
      bus.d_data  = rnd64();
      @(negedge clk);
      chk("A a_valid", 64'(bus.a_valid), 64'd1);
      chk("A a_address", bus.a_address, ea);
      chk("A a_opcode", 64'(bus.a_opcode), 64'(eo));
      chk("A a_size", 64'(bus.a_size), 64'(es));
      chk("A a_data", bus.a_data, ew);
      chk("A d_ready", 64'(bus.d_ready), 64'd0);
      chk("A rvalid", 64'({rvalid0, rvalid1}), 64'd0);
      chk("A gnt0", 64'(gnt0), 64'((c == stall) && !o));
      chk("A gnt1", 64'(gnt1), 64'((c == stall) && o));
    end
    @(posedge clk); #1;
    bus.a_ready = 1'b0;
    flush0      = 1'b0;
    bus.d_valid = 1'b0;
    if (o) req1 = 1'b0; else req0 = 1'b0;
    for (int b = 0; b < beats; b++) begin
      if (b == 1 || (flush_at > 0 && b == flush_at)) begin
        flush0 = (flush_at > 0 && b == flush_at);
        @(negedge clk);
        chk("D gap rvalid", 64'({rvalid0, rvalid1}), 64'd0);
        chk("D gap busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        flush0 = 1'b0;
      end
      dropped     = !o && flush_at >= 0 && b >= flush_at;
      dd          = rnd64();
      bus.d_valid = 1'b1;
      bus.d_data  = dd;
      sb.push_back('{v0: !o && !dropped, v1: o, data: dd, last: (b == beats - 1)});
      @(negedge clk);
      chk("D d_ready", 64'(bus.d_ready), 64'd1);
      e = sb.pop_front();
      chk("D rvalid0", 64'(rvalid0), 64'(e.v0));
      chk("D rvalid1", 64'(rvalid1), 64'(e.v1));
      chk("D rdata", rdata, e.data);
      chk("D rlast", 64'(rlast), 64'(e.last));
      @(posedge clk); #1;
      bus.d_valid = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; flush0 = 1'b0;
    op0 = '0; op1 = '0; size0 = '0; size1 = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    bus.a_ready = 1'b0; bus.d_valid = 1'b0; bus.d_data = '0;

    tbl[0]  = '{2, GET, 3'd3, 64'h1000,      64'h0,        0, -1, 1'b0, 1};
    tbl[1]  = '{3, GET, 3'd3, 64'h0,         64'h0,        0, -1, 1'b1, 1};
    tbl[2]  = '{2, GET, 3'd4, 64'h2000,      64'h0,        0, -1, 1'b0, 2};
    tbl[3]  = '{3, GET, 3'd4, 64'h0,         64'h0,        0, -1, 1'b1, 2};
    tbl[4]  = '{0, GET, 3'd5, 64'h8000_0000, 64'h0,        0, -1, 1'b0, 4};
    tbl[5]  = '{1, GET, 3'd6, 64'h3000,      64'h0,        5, -1, 1'b1, 8};
    tbl[6]  = '{2, GET, 3'd5, 64'h4000,      64'h0,        0,  2, 1'b0, 4};
    tbl[7]  = '{3, GET, 3'd5, 64'h0,         64'h0,        0,  1, 1'b1, 4};
    tbl[8]  = '{1, PUT, 3'd3, 64'h5000,      64'hDEADBEEF, 0,  0, 1'b1, 1};
    tbl[9]  = '{0, GET, 3'd7, 64'h6000,      64'h0,        2,  0, 1'b0, 8};
    tbl[10] = '{0, GET, 3'd0, 64'h7001,      64'h0,        0, -1, 1'b0, 1};
    tbl[11] = '{0, PUT, 3'd2, 64'h7100,      64'h55,       0, -1, 1'b0, 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      if (tbl[i].post != 3) post(tbl[i].post, tbl[i].op, tbl[i].size, tbl[i].addr, tbl[i].wdata);
      serve(tbl[i].owner, tbl[i].beats, tbl[i].stall, tbl[i].flush_at);
    end

    // flush0 while IDLE must not affect the transaction being arbitrated
    post(0, GET, 3'd4, 64'h9000, 64'h0);
    flush0 = 1'b1;
    serve(1'b0, 2, 0, -1);

    // D-channel traffic while IDLE is not accepted or forwarded
    bus.d_valid = 1'b1;
    bus.d_data  = rnd64();
    @(negedge clk);
    chk("idle d_ready", 64'(bus.d_ready), 64'd0);
    chk("idle rvalid", 64'({rvalid0, rvalid1}), 64'd0);
    chk("idle busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    bus.d_valid = 1'b0;

    // Reset during the second D beat abandons the transaction
    post(0, GET, 3'd5, 64'hA000, 64'h0);
    @(posedge clk); #1;
    bus.a_ready = 1'b1;
    @(negedge clk);
    chk("rst gnt0", 64'(gnt0), 64'd1);
    @(posedge clk); #1;
    bus.a_ready = 1'b0; req0 = 1'b0;
    bus.d_valid = 1'b1; bus.d_data = rnd64();
    @(negedge clk);
    chk("rst beat1 rvalid0", 64'(rvalid0), 64'd1);
    @(posedge clk); #1;
    bus.d_data = rnd64();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus.d_data = rnd64();
      @(negedge clk);
      chk("midrst late rvalid0", 64'(rvalid0), 64'd0);
      chk("midrst late busy", 64'(busy), 64'd0);
    end
    @(posedge clk); #1;
    bus.d_valid = 1'b0;

    // After reset port 0 again wins the first tie
    post(2, GET, 3'd3, 64'hB000, 64'h0);
    serve(1'b0, 1, 0, -1);
    serve(1'b1, 1, 0, -1);

    chk("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
